// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types for the fetch / load-store SRAM arbiter.
// Holds the response-owner FSM encoding and the starvation-counter width helper.
package mem_bus_arbiter_pkg;

    // Who owns the read data returning from the SRAM this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_RSP = 2'd1,
        ARB_LS_RSP = 2'd2
    } arb_state_e;

    // Bits needed to count 0..max_v inclusive.
    function automatic int cnt_width(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_starve_cnt.sv
// arb_starve_cnt: counts consecutive cycles in which fetch wanted the bus but
// lost it to load/store, saturating at STARVE_MAX. starve_hit_o tells the
// arbiter to let fetch win the next contested cycle.
module arb_starve_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic flush_i,
    output logic starve_hit_o
);

    localparam int CW = cnt_width(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear when fetch is served, idle or flushed; else saturate upward.
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt_i || !if_req_i || flush_i)
            cnt_d = '0;
        else if (cnt_q != CW'(STARVE_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign starve_hit_o = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port SRAM between instruction fetch and
// the load/store unit. Load/store has priority; grants are combinational, read
// data returns one cycle later and is steered to the owner. flush blocks fetch
// grants and drops a fetch response returning in that cycle.
// Optional: define ARB_STARVE_GUARD_EN to force a fetch win after STARVE_MAX
// consecutive fetch losses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    input  logic                flush,
    output logic                stall_o,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state_q;
    logic       if_ok;
    logic       force_if;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_gnt_i    (if_gnt),
        .flush_i     (flush),
        .starve_hit_o(force_if)
    );
`else
    localparam int unused_starve_max = STARVE_MAX;
    assign force_if = 1'b0;
`endif

    // Fetch is eligible only outside flush and reset; a starving fetch beats load/store.
    assign if_ok   = if_req & ~flush & ~rst;
    assign ls_gnt  = ls_req & ~rst & ~(force_if & if_ok);
    assign if_gnt  = if_ok & ~ls_gnt;
    assign stall_o = if_req & ~if_gnt & ~rst;

    // SRAM port mux: the granted requester drives the bus, otherwise all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we ? ls_be : '0;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    // Response-owner FSM: remember who gets next cycle's read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   state_q <= ARB_IDLE;
        else if (if_gnt)           state_q <= ARB_IF_RSP;
        else if (ls_gnt && !ls_we) state_q <= ARB_LS_RSP;
        else                       state_q <= ARB_IDLE;
    end

    assign if_rvalid = (state_q == ARB_IF_RSP) & ~flush;
    assign ls_rvalid = (state_q == ARB_LS_RSP);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus a randomized run checked against a
// behavioural model of the arbitration rules and a reference memory image.
module tb_mem_bus_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          flush, stall_o, mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .flush(flush), .stall_o(stall_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port SRAM: 64 words, byte-write, one-cycle read latency.
    logic [DW-1:0] sram [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != '0) begin
                for (int b = 0; b < BW; b++)
                    if (mem_we[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:2]];
            end
        end
    end

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = '0;
        ls_addr = '0; ls_wdata = '0; flush = 0;
    endtask

    // Single full-word store through the arbiter, one cycle.
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ls_req = 1; ls_we = 1; ls_be = '1; ls_addr = a; ls_wdata = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; if_req = 1; ls_req = 1; ls_addr = 32'h40; if_addr = 32'h8;
        #1;
        checks++;
        if ({if_gnt, ls_gnt, stall_o, mem_en, mem_we, if_rvalid, ls_rvalid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b/%b stall=%b en=%b we=%b rv=%b/%b want all 0",
                     if_gnt, ls_gnt, stall_o, mem_en, mem_we, if_rvalid, ls_rvalid);
        end
        idle_inputs();
        @(negedge clk); rst = 0;
        #1;
        checks++;
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            errors++; $display("FAIL reset_release_rvalid: got %b%b want 00", if_rvalid, ls_rvalid);
        end
    endtask

    task automatic test_fetch_seq();
        do_store(32'h0, 32'h0000_0013);
        #1;
        checks++;
        if (ls_gnt !== 1'b1 || mem_we !== 4'hF) begin
            errors++; $display("FAIL preload_store: got gnt=%b we=%h want 1/f", ls_gnt, mem_we);
        end
        do_store(32'h4, 32'h0010_0093);
        @(negedge clk);
        idle_inputs(); if_req = 1; if_addr = 32'h0;
        #1;
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 4'h0) begin
            errors++; $display("FAIL fetch0_grant: got gnt=%b addr=%h we=%h want 1/0/0", if_gnt, mem_addr, mem_we);
        end
        @(negedge clk);
        if_addr = 32'h4;
        #1;
        checks++;
        if (if_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL fetch0_rsp: got gnt=%b rv=%b data=%h want 1/1/00000013", if_gnt, if_rvalid, if_rdata);
        end
        @(negedge clk);
        if_req = 0;
        #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0010_0093) begin
            errors++; $display("FAIL fetch4_rsp: got rv=%b data=%h want 1/00100093", if_rvalid, if_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== '0) begin
            errors++; $display("FAIL fetch_idle_rsp: got rv=%b data=%h want 0/0", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_contention();
        do_store(32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        idle_inputs(); ls_req = 1; ls_addr = 32'h100; if_req = 1; if_addr = 32'h8;
        #1;
        checks++;
        if ({ls_gnt, if_gnt, stall_o} !== 3'b101 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL contention_grant: got ls/if/stall=%b%b%b addr=%h want 101/100",
                               ls_gnt, if_gnt, stall_o, mem_addr);
        end
        @(negedge clk);
        ls_req = 0;
        #1;
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEAD_BEEF || if_gnt !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL contention_rsp: got rv=%b data=%h if_gnt=%b stall=%b want 1/deadbeef/1/0",
                               ls_rvalid, ls_rdata, if_gnt, stall_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_store_be();
        do_store(32'h200, 32'h0);
        @(negedge clk);
        ls_be = 4'b0011; ls_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (ls_gnt !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL store_be: got gnt=%b we=%b wdata=%h want 1/0011/12345678", ls_gnt, mem_we, mem_wdata);
        end
        @(negedge clk);
        ls_we = 0; ls_be = '0;
        #1;
        checks++;
        if (ls_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_no_rvalid: got %b want 0", ls_rvalid);
        end
        @(negedge clk);
        ls_req = 0;
        #1;
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0000_5678) begin
            errors++; $display("FAIL store_be_readback: got rv=%b data=%h want 1/00005678", ls_rvalid, ls_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush();
        @(negedge clk);
        if_req = 1; if_addr = 32'h0;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL flush_pre_grant: got %b want 1", if_gnt);
        end
        @(negedge clk);
        flush = 1; if_addr = 32'h4;
        #1;
        checks++;
        if ({if_rvalid, if_gnt, stall_o} !== 3'b001 || if_rdata !== '0) begin
            errors++; $display("FAIL flush_drop: got rv/gnt/stall=%b%b%b data=%h want 001/0",
                               if_rvalid, if_gnt, stall_o, if_rdata);
        end
        @(negedge clk);
        flush = 0; if_req = 0;
        #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++; $display("FAIL flush_no_replay: got %b want 0", if_rvalid);
        end
    endtask

    task automatic test_starve();
        @(negedge clk);
        idle_inputs(); if_req = 1; if_addr = 32'h8; ls_req = 1; ls_addr = 32'h100;
        for (int i = 0; i < 2 * (SMAX + 1); i++) begin
            logic exp_if;
            if (i != 0) @(negedge clk);
            #1;
            // With the guard, fetch wins every (SMAX+1)th consecutive contested cycle.
            exp_if = GUARD && (((i + 1) % (SMAX + 1)) == 0);
            checks++;
            if ({if_gnt, ls_gnt} !== {exp_if, ~exp_if}) begin
                errors++; $display("FAIL starve_cycle%0d: got if/ls=%b%b want %b%b",
                                   i, if_gnt, ls_gnt, exp_if, ~exp_if);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        ls_req = 1; ls_we = 0; ls_addr = 32'h100;
        #1;
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++; $display("FAIL midrst_grant: got %b want 1", ls_gnt);
        end
        @(posedge clk);
        #1 ls_req = 1; if_req = 1; if_addr = 32'h4;
        #1 rst = 1;
        #1;
        checks++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, stall_o, mem_en, mem_we, mem_addr, mem_wdata,
             if_rdata, ls_rdata} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got gnt=%b%b rv=%b%b stall=%b en=%b we=%h addr=%h want all 0",
                               if_gnt, ls_gnt, if_rvalid, ls_rvalid, stall_o, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        idle_inputs(); rst = 0;
        #1;
        checks++;
        if ({ls_rvalid, if_rvalid} !== 2'b00) begin
            errors++; $display("FAIL midrst_release: got ls/if rv=%b%b want 00", ls_rvalid, if_rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ls_rvalid, if_rvalid} !== 2'b00) begin
            errors++; $display("FAIL midrst_release2: got ls/if rv=%b%b want 00", ls_rvalid, if_rvalid);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [0:63];
        int            pend;        // 0 none, 1 fetch data due, 2 load data due
        logic [DW-1:0] pend_data;
        int            starve;
        bit            if_taken, ls_taken;
        logic          e_force, e_ls, e_if, e_stall, e_ifv, e_lsv, e_men;
        logic [BW-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;

        for (int w = 0; w < 64; w++) begin
            ref_mem[w] = $urandom;
            do_store({24'h0, w[5:0], 2'b00}, ref_mem[w]);
        end
        @(negedge clk);
        idle_inputs();
        pend = 0; pend_data = '0; starve = 0; if_taken = 1; ls_taken = 1;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            // Requesters hold until granted, then pick a fresh request (or go idle).
            if (!if_req || if_taken) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!ls_req || ls_taken) begin
                ls_req   = ($urandom_range(0, 99) < 50);
                ls_we    = ($urandom_range(0, 99) < 35);
                ls_be    = 4'($urandom_range(0, 15));
                ls_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                ls_wdata = $urandom;
            end
            flush = ($urandom_range(0, 99) < 15);
            #1;

            e_force = GUARD && (starve == SMAX) && if_req && !flush;
            e_ls    = ls_req && !e_force;
            e_if    = if_req && !flush && !e_ls;
            e_stall = if_req && !e_if;
            e_ifv   = (pend == 1) && !flush;
            e_lsv   = (pend == 2);
            e_men   = e_ls || e_if;
            e_we    = (e_ls && ls_we) ? ls_be : '0;
            e_addr  = e_ls ? ls_addr : (e_if ? if_addr : '0);
            e_wdata = e_ls ? ls_wdata : '0;

            checks++;
            if ({if_gnt, ls_gnt, stall_o} !== {e_if, e_ls, e_stall}) begin
                errors++; $display("FAIL rnd_grant c%0d: got if/ls/stall=%b%b%b want %b%b%b",
                                   c, if_gnt, ls_gnt, stall_o, e_if, e_ls, e_stall);
            end
            checks++;
            if ({if_rvalid, if_rdata} !== {e_ifv, (e_ifv ? pend_data : 32'h0)}) begin
                errors++; $display("FAIL rnd_if_rsp c%0d: got rv=%b data=%h want rv=%b data=%h",
                                   c, if_rvalid, if_rdata, e_ifv, e_ifv ? pend_data : 32'h0);
            end
            checks++;
            if ({ls_rvalid, ls_rdata} !== {e_lsv, (e_lsv ? pend_data : 32'h0)}) begin
                errors++; $display("FAIL rnd_ls_rsp c%0d: got rv=%b data=%h want rv=%b data=%h",
                                   c, ls_rvalid, ls_rdata, e_lsv, e_lsv ? pend_data : 32'h0);
            end
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_men, e_we, e_addr, e_wdata}) begin
                errors++; $display("FAIL rnd_mem c%0d: got en=%b we=%h addr=%h wd=%h want en=%b we=%h addr=%h wd=%h",
                                   c, mem_en, mem_we, mem_addr, mem_wdata, e_men, e_we, e_addr, e_wdata);
            end

            // Advance the model to the next cycle.
            if (e_if) begin
                pend = 1; pend_data = ref_mem[if_addr[7:2]];
            end else if (e_ls && !ls_we) begin
                pend = 2; pend_data = ref_mem[ls_addr[7:2]];
            end else begin
                pend = 0;
            end
            if (e_ls && ls_we)
                for (int b = 0; b < BW; b++)
                    if (ls_be[b]) ref_mem[ls_addr[7:2]][8*b +: 8] = ls_wdata[8*b +: 8];
            if (e_if || !if_req || flush) starve = 0;
            else if (starve < SMAX)       starve++;
            if_taken = e_if;
            ls_taken = e_ls;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_fetch_seq();
        test_contention();
        test_store_be();
        test_flush();
        test_starve();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
